parity_scrub_reader: RTL

- Sequential read controller for the odd-parity-protected byte memory; the reading counterpart of the parity-generating write path.
- On START it walks every address from 0 to DEPTH-1, issues a READ strobe and captures data plus stored parity.
- It checks odd parity on each word, streams each word out, counts parity errors and records the first failing address.

---
 rtl/parity_scrub_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/parity_scrub_reader.sv
// parity_scrub_reader
//
// Sequential read controller for an odd-parity-protected word memory.
// On START it walks every address 0..DEPTH-1. For each word it issues a
// one-cycle READ strobe, captures DIN/PIN, checks odd parity, streams the
// word out and accumulates error statistics for the pass.
//
// Ports:
//   CLK         rising-edge clock
//   RST_N       asynchronous active-low reset
//   START       begin a scan pass (sampled in IDLE only)
//   ABORT       synchronous abort of a running pass
//   READ        memory read strobe, one cycle per word
//   ADDR        memory address, valid while READ=1
//   DIN, PIN    memory data and stored parity, sampled when the word is captured
//   DATA_OUT    captured word
//   DATA_VALID  one-cycle pulse with each captured word
//   PERR        parity error for the current DATA_OUT
//   BUSY        high from the cycle after START until DONE
//   DONE        one-cycle pulse at the end of a full pass
//   ERROR       sticky: at least one parity error in the current/last pass
//   ERR_CNT     parity-error count for the pass (saturates at DEPTH)
//   ERR_ADDR    address of the first parity error, valid when ERROR=1

module parity_scrub_reader #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic          ABORT,
    output logic          READ,
    output logic [AW-1:0] ADDR,
    input  logic [DW-1:0] DIN,
    input  logic          PIN,
    output logic [DW-1:0] DATA_OUT,
    output logic          DATA_VALID,
    output logic          PERR,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERROR,
    output logic [AW:0]   ERR_CNT,
    output logic [AW-1:0] ERR_ADDR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RDREQ = 2'd1,
        CAPT  = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Error count ceiling: DEPTH = 2**AW, i.e. only the MSB of ERR_CNT set.
    localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};

    state_t          state;
    logic [AW-1:0]   addr;
    logic            word_err;

    // Good word has an odd number of ones across {DIN, PIN}.
    assign word_err = ~(^{DIN, PIN});

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            addr       <= '0;
            READ       <= 1'b0;
            ADDR       <= '0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            PERR       <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            ERR_CNT    <= '0;
            ERR_ADDR   <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            READ       <= 1'b0;
            DATA_VALID <= 1'b0;
            DONE       <= 1'b0;

            case (state)
                IDLE: begin
                    // START takes priority over ABORT here; ABORT is a no-op in IDLE.
                    if (START) begin
                        ERROR    <= 1'b0;
                        ERR_CNT  <= '0;
                        ERR_ADDR <= '0;
                        addr     <= '0;
                        BUSY     <= 1'b1;
                        state    <= RDREQ;
                    end
                end

                RDREQ: begin
                    if (ABORT) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        READ  <= 1'b1;
                        ADDR  <= addr;
                        state <= CAPT;
                    end
                end

                CAPT: begin
                    if (ABORT) begin
                        // Word in flight is dropped: no capture, no DATA_VALID.
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        DATA_OUT   <= DIN;
                        PERR       <= word_err;
                        DATA_VALID <= 1'b1;
                        if (word_err) begin
                            if (ERR_CNT != CNT_MAX) begin
                                ERR_CNT <= ERR_CNT + (AW+1)'(1);
                            end
                            if (!ERROR) begin
                                ERR_ADDR <= addr;
                                ERROR    <= 1'b1;
                            end
                        end
                        if (addr == '1) begin
                            state <= FIN;
                        end else begin
                            addr  <= addr + AW'(1);
                            state <= RDREQ;
                        end
                    end
                end

                FIN: begin
                    if (!ABORT) begin
                        DONE <= 1'b1;
                    end
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
